// File: rtl/freq_counter_wb_slave.sv
// rtl/freq_counter_wb_slave.sv - Wishbone-mapped gated frequency counter with interpolation
//
// Counts rising edges of sig_i over a gate of GATE_CYCLES clk_i cycles, then
// measures the clk_i cycles from the gate end to the next rising edge
// (interpolation), saturating at INTERP_MAX.
//
// Ports:
//    clk_i            system clock
//    ext_rst_i        asynchronous active-low reset
//    adr_i, dat_i     Wishbone address / write data (32 bit)
//    dat_o            Wishbone read data, registered
//    we_i, sel_i      write enable, byte-lane select
//    cyc_i, stb_i     bus cycle, strobe
//    ack_o, err_o     terminations (err_o for unmapped addresses)
//    rty_o            retry, always 0
//    sig_i            measured signal, asynchronous to clk_i
//    busy_o, done_o   measurement in progress / result available
//
// Register map: 0x8 CTRL/STATUS (bit0 CLR, bit7 START on write;
// bit5 BUSY, bit6 DONE on read), 0x9 COUNT (RO), 0xA INTERP (RO).

module freq_counter_wb_slave #(
   parameter logic [31:0] GATE_CYCLES = 32'd50000000,
   parameter logic [31:0] INTERP_MAX  = 32'hFFFFFFFF
) (
   input  logic        clk_i,
   input  logic        ext_rst_i,
   input  logic [31:0] adr_i,
   input  logic [31:0] dat_i,
   output logic [31:0] dat_o,
   input  logic        we_i,
   input  logic [3:0]  sel_i,
   input  logic        cyc_i,
   input  logic        stb_i,
   output logic        ack_o,
   output logic        err_o,
   output logic        rty_o,
   input  logic        sig_i,
   output logic        busy_o,
   output logic        done_o
);

   localparam logic [31:0] ADR_CTRL   = 32'h0000_0008;
   localparam logic [31:0] ADR_COUNT  = 32'h0000_0009;
   localparam logic [31:0] ADR_INTERP = 32'h0000_000A;
   localparam logic [31:0] COUNT_MAX  = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      S_IDLE,
      S_GATE,
      S_INTERP,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] count_q, count_d;
   logic [31:0] interp_q, interp_d;
   logic [31:0] gate_cnt_q, gate_cnt_d;

   logic sync1_q, sync2_q, sync3_q;
   logic sig_edge;

   logic        req;
   logic        hit_ctrl, hit_count, hit_interp, mapped;
   logic        ctrl_wr, clr_cmd, start_cmd;
   logic [31:0] rd_data;
   logic        unused_bits;

   // ---------------- bus decode ----------------
   // Masking with the outputs makes a continuously held strobe terminate
   // every second cycle.
   assign req        = cyc_i & stb_i & ~ack_o & ~err_o;
   assign hit_ctrl   = (adr_i == ADR_CTRL);
   assign hit_count  = (adr_i == ADR_COUNT);
   assign hit_interp = (adr_i == ADR_INTERP);
   assign mapped     = hit_ctrl | hit_count | hit_interp;

   assign ctrl_wr   = req & we_i & hit_ctrl & sel_i[0];
   assign clr_cmd   = ctrl_wr & dat_i[0];
   assign start_cmd = ctrl_wr & dat_i[7];

   assign busy_o = (state_q == S_GATE) || (state_q == S_INTERP);
   assign done_o = (state_q == S_DONE);
   assign rty_o  = 1'b0;

   assign unused_bits = ^{sel_i[3:1], dat_i[31:8], dat_i[6:1]};

   always_comb begin
      rd_data = 32'h0;
      if (hit_ctrl)
         rd_data = {24'b0, 1'b0, done_o, busy_o, 5'b0};
      else if (hit_count)
         rd_data = count_q;
      else if (hit_interp)
         rd_data = interp_q;
   end

   always_ff @(posedge clk_i or negedge ext_rst_i) begin
      if (!ext_rst_i) begin
         ack_o <= 1'b0;
         err_o <= 1'b0;
         dat_o <= 32'h0;
      end else begin
         ack_o <= req & mapped;
         err_o <= req & ~mapped;
         dat_o <= (req & mapped & ~we_i) ? rd_data : 32'h0;
      end
   end

   // ---------------- input synchronizer ----------------
   // Two flops for metastability, the third remembers the previous
   // synchronized level; a detected edge is a synchronized 0->1.
   always_ff @(posedge clk_i or negedge ext_rst_i) begin
      if (!ext_rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= sig_i;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign sig_edge = sync2_q & ~sync3_q;

   // ---------------- measurement FSM ----------------
   always_ff @(posedge clk_i or negedge ext_rst_i) begin
      if (!ext_rst_i) begin
         state_q    <= S_IDLE;
         count_q    <= 32'h0;
         interp_q   <= 32'h0;
         gate_cnt_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         interp_q   <= interp_d;
         gate_cnt_q <= gate_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      interp_d   = interp_q;
      gate_cnt_d = gate_cnt_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_cmd) begin
               count_d    = 32'h0;
               interp_d   = 32'h0;
               gate_cnt_d = 32'h0;
               state_d    = S_GATE;
            end
         end

         S_GATE: begin
            gate_cnt_d = gate_cnt_q + 32'd1;
            if (sig_edge && (count_q != COUNT_MAX))
               count_d = count_q + 32'd1;
            // The edge in the final gate cycle is still counted above.
            if (gate_cnt_q == GATE_CYCLES - 32'd1)
               state_d = S_INTERP;
         end

         S_INTERP: begin
            if (sig_edge || (interp_q == INTERP_MAX))
               state_d = S_DONE;
            else
               interp_d = interp_q + 32'd1;
         end

         default: state_d = S_IDLE;
      endcase

      // CLR overrides everything, including a START in the same write.
      if (clr_cmd) begin
         count_d    = 32'h0;
         interp_d   = 32'h0;
         gate_cnt_d = 32'h0;
         state_d    = S_IDLE;
      end
   end

endmodule

// File: tb/tb_freq_counter_wb_slave.sv
// tb/tb_freq_counter_wb_slave.sv - directed self-checking bench for freq_counter_wb_slave

module tb_freq_counter_wb_slave;

   logic        clk_i = 1'b0;
   logic        ext_rst_i;
   logic [31:0] adr_i;
   logic [31:0] dat_i;
   logic [31:0] dat_o;
   logic        we_i;
   logic [3:0]  sel_i;
   logic        cyc_i;
   logic        stb_i;
   logic        ack_o;
   logic        err_o;
   logic        rty_o;
   logic        sig_i;
   logic        busy_o;
   logic        done_o;

   int total = 0;
   int bad   = 0;
   int ecnt  = 0;
   int base  = 0;
   int sig_mode = 0;

   logic [31:0] rd;
   logic        ak, er;

   always #5 clk_i = ~clk_i;

   freq_counter_wb_slave #(
      .GATE_CYCLES (32'd100),
      .INTERP_MAX  (32'd20)
   ) dut (
      .clk_i     (clk_i),
      .ext_rst_i (ext_rst_i),
      .adr_i     (adr_i),
      .dat_i     (dat_i),
      .dat_o     (dat_o),
      .we_i      (we_i),
      .sel_i     (sel_i),
      .cyc_i     (cyc_i),
      .stb_i     (stb_i),
      .ack_o     (ack_o),
      .err_o     (err_o),
      .rty_o     (rty_o),
      .sig_i     (sig_i),
      .busy_o    (busy_o),
      .done_o    (done_o)
   );

   initial forever begin
      @(posedge clk_i);
      ecnt++;
   end

   // sig_i stimulus, j counts clocks after the edge that sampled START.
   // Mode 1: rise at j=3 then every 10 clocks -> detected edges in gate cycles 5,15,...
   // Mode 2: single rise at j=105 -> detected edge in interpolation cycle 7.
   initial begin
      sig_i = 1'b0;
      forever begin
         @(posedge clk_i);
         #2;
         begin
            int j;
            j = ecnt - base;
            case (sig_mode)
               1: sig_i = (j >= 3) && (((j - 3) % 10) < 5);
               2: sig_i = (j >= 105);
               default: sig_i = 1'b0;
            endcase
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wb(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                     input logic [3:0] sel, output logic [31:0] rdat,
                     output logic a, output logic e);
      @(posedge clk_i);
      #1;
      adr_i = adr; we_i = we; dat_i = dat; sel_i = sel;
      cyc_i = 1'b1; stb_i = 1'b1;
      @(posedge clk_i);
      #1;
      rdat = dat_o; a = ack_o; e = err_o;
      cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
   endtask

   task automatic start_meas(input int mode);
      sig_mode = 0;
      wb(32'h8, 1'b1, 32'h80, 4'hF, rd, ak, er);
      base = ecnt;
      sig_mode = mode;
   endtask

   task automatic wait_to(input int n);
      while (ecnt < base + n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic wait_done(input string tag, input int lim);
      int n = 0;
      while (!done_o && n < lim) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      chk(tag, done_o, 1);
   endtask

   initial begin
      ext_rst_i = 1'b0;
      adr_i = 0; dat_i = 0; we_i = 0; sel_i = 0; cyc_i = 0; stb_i = 0;

      // reset state
      #12;
      chk("rst_ack", ack_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_dat", dat_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rty", rty_o, 0);
      @(posedge clk_i); @(posedge clk_i); #1;
      ext_rst_i = 1'b1;

      // first access after reset
      wb(32'h8, 1'b0, 0, 4'hF, rd, ak, er);
      chk("first_ack", ak, 1);
      chk("first_ctrl", rd, 0);

      // unmapped address
      wb(32'h4, 1'b0, 0, 4'hF, rd, ak, er);
      chk("unmap_err", er, 1);
      chk("unmap_ack", ak, 0);
      chk("unmap_dat", rd, 0);
      @(posedge clk_i); #1;
      chk("unmap_err_pulse", err_o, 0);

      // START without lane 0, and a write to a read-only register
      wb(32'h8, 1'b1, 32'h80, 4'b0010, rd, ak, er);
      chk("sel_ack", ak, 1);
      @(posedge clk_i); #1;
      chk("sel_busy", busy_o, 0);
      wb(32'h9, 1'b1, 32'h1234, 4'hF, rd, ak, er);
      chk("ro_wr_ack", ak, 1);
      chk("ro_wr_dat", rd, 0);
      wb(32'h9, 1'b0, 0, 4'hF, rd, ak, er);
      chk("ro_wr_count", rd, 0);

      // held strobe terminates every second cycle
      begin
         int n = 0;
         @(posedge clk_i); #1;
         adr_i = 32'h8; we_i = 0; sel_i = 4'hF; cyc_i = 1; stb_i = 1;
         repeat (4) begin
            @(posedge clk_i); #1;
            if (ack_o) n++;
         end
         cyc_i = 0; stb_i = 0;
         chk("stb_hold_acks", n, 2);
      end

      // periodic signal: 10 edges in gate, interpolation 5
      start_meas(1);
      chk("a_busy", busy_o, 1);
      wait_to(38);
      wb(32'h9, 1'b0, 0, 4'hF, rd, ak, er);
      chk("a_live_count", rd, 4);
      wait_done("a_done_wait", 300);
      wb(32'h9, 1'b0, 0, 4'hF, rd, ak, er);
      chk("a_count", rd, 10);
      wb(32'hA, 1'b0, 0, 4'hF, rd, ak, er);
      chk("a_interp", rd, 5);
      wb(32'h8, 1'b0, 0, 4'hF, rd, ak, er);
      chk("a_ctrl", rd, 32'h40);
      chk("a_busy_end", busy_o, 0);

      // single edge 7 cycles into interpolation; START while busy ignored
      sig_mode = 0;
      repeat (10) @(posedge clk_i);
      start_meas(2);
      wait_to(50);
      wb(32'h8, 1'b1, 32'h80, 4'hF, rd, ak, er);
      chk("b_start_busy_ack", ak, 1);
      wait_done("b_done_wait", 300);
      wb(32'h9, 1'b0, 0, 4'hF, rd, ak, er);
      chk("b_count", rd, 0);
      wb(32'hA, 1'b0, 0, 4'hF, rd, ak, er);
      chk("b_interp", rd, 7);
      chk("b_done", done_o, 1);

      // no edges: interpolation saturates at INTERP_MAX
      sig_mode = 0;
      repeat (10) @(posedge clk_i);
      start_meas(0);
      wait_done("c_done_wait", 300);
      wb(32'h9, 1'b0, 0, 4'hF, rd, ak, er);
      chk("c_count", rd, 0);
      wb(32'hA, 1'b0, 0, 4'hF, rd, ak, er);
      chk("c_interp", rd, 20);
      chk("c_done", done_o, 1);

      // CLR+START mid-gate
      start_meas(1);
      wait_to(30);
      wb(32'h8, 1'b1, 32'h81, 4'hF, rd, ak, er);
      chk("d_clr_ack", ak, 1);
      chk("d_clr_busy", busy_o, 0);
      wb(32'h9, 1'b0, 0, 4'hF, rd, ak, er);
      chk("d_count", rd, 0);
      wb(32'hA, 1'b0, 0, 4'hF, rd, ak, er);
      chk("d_interp", rd, 0);
      wb(32'h8, 1'b0, 0, 4'hF, rd, ak, er);
      chk("d_ctrl", rd, 0);

      // reset mid-interpolation, then a full measurement
      sig_mode = 0;
      repeat (10) @(posedge clk_i);
      start_meas(0);
      wait_to(110);
      chk("e_busy_pre", busy_o, 1);
      #2;
      ext_rst_i = 1'b0;
      #1;
      chk("e_rst_busy", busy_o, 0);
      chk("e_rst_done", done_o, 0);
      chk("e_rst_ack", ack_o, 0);
      chk("e_rst_err", err_o, 0);
      chk("e_rst_dat", dat_o, 0);
      #3;
      ext_rst_i = 1'b1;
      wb(32'hA, 1'b0, 0, 4'hF, rd, ak, er);
      chk("e_post_ack", ak, 1);
      chk("e_post_interp", rd, 0);
      start_meas(1);
      wait_done("e_done_wait", 300);
      wb(32'h9, 1'b0, 0, 4'hF, rd, ak, er);
      chk("e_count", rd, 10);
      wb(32'hA, 1'b0, 0, 4'hF, rd, ak, er);
      chk("e_interp", rd, 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/freq_counter_wb_slave.md
FREQ_COUNTER_WB_SLAVE -- requirements
Module: freq_counter_wb_slave

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 32'd50000000, meaning the gate window length in clk_i cycles.
REQ-002 SHALL have parameter INTERP_MAX, default 32'hFFFFFFFF, meaning the saturation limit of the interpolation counter.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk_i  input  1  system clock; all state changes on its rising edge.
REQ-005 ext_rst_i  input  1  asynchronous active-low reset.
REQ-006 adr_i  input  32  Wishbone address.
REQ-007 dat_i  input  32  Wishbone write data.
REQ-008 dat_o  output  32  Wishbone read data, registered.
REQ-009 we_i  input  1  write enable.
REQ-010 sel_i  input  4  byte-lane select.
REQ-011 cyc_i, stb_i  input  1 each  bus cycle and strobe.
REQ-012 ack_o, err_o, rty_o  output  1 each  Wishbone termination; rty_o tied 0.
REQ-013 sig_i  input  1  measured signal, asynchronous to clk_i.
REQ-014 busy_o, done_o  output  1 each  status mirrors of CTRL bits 5 and 6.

Function
REQ-015 Bus: request = cyc_i & stb_i & ~ack_o & ~err_o; sampled request SHALL produce a one-cycle pulse of ack_o (mapped address) or err_o (unmapped address) on the next cycle; stb held high continuously yields a termination every second cycle.
REQ-016 Map: 0x8 CTRL/STATUS, 0x9 COUNT (RO), 0xA INTERP (RO); all other addresses SHALL return err_o and have no side effects.
REQ-017 dat_o SHALL be loaded in the request cycle and valid while ack_o is high; reads of CTRL return {24'b0, 1'b0, DONE, BUSY, 5'b0}; dat_o SHALL be 0 for writes and errors.
REQ-018 CTRL write acts only when sel_i[0]=1: dat_i[0]=1 is CLR, dat_i[7]=1 is START; writes to 0x9/0xA, and CTRL writes with sel_i[0]=0, SHALL be acked and ignored.
REQ-019 sig_i SHALL pass through a 2-flop synchronizer plus an edge-detect flop; a "detected edge" is a 0->1 transition of the synchronized signal (latency 3 cycles from pin).
REQ-020 FSM states IDLE, GATE, INTERP, DONE; BUSY=1 in GATE/INTERP; DONE=1 only in DONE.
REQ-021 IDLE or DONE + START: COUNT<=0, INTERP<=0, gate counter<=0, next state GATE.
REQ-022 GATE: gate counter increments each cycle; each detected edge increments COUNT, saturating at 32'hFFFFFFFF; when gate counter == GATE_CYCLES-1, the state SHALL go to INTERP and an edge in that final cycle SHALL be counted.
REQ-023 INTERP: INTERP increments every cycle; on a detected edge, or when INTERP == INTERP_MAX, the state SHALL go to DONE without incrementing INTERP; edges here do not affect COUNT.
REQ-024 DONE: COUNT/INTERP are held until START or CLR.
REQ-025 START while BUSY SHALL be ignored.
REQ-026 CLR in any state SHALL zero COUNT, INTERP and the gate counter and force IDLE the next cycle; CLR beats START when both are set in one write.
REQ-027 COUNT/INTERP reads during a measurement SHALL return live values.

Reset
REQ-028 ext_rst_i low SHALL immediately force IDLE, with ack_o=err_o=0, dat_o=0, COUNT=INTERP=0, busy_o=done_o=0, and synchronizer flops at 0; a measurement in progress is discarded.
REQ-029 After ext_rst_i deasserts, the first request SHALL be serviced normally, with no spurious edge counted from synchronizer initialisation.

Verification (bench GATE_CYCLES=100)
REQ-030 Write 0x80 to 0x8 with sig_i of period 10 clk whose first detected edge is at gate cycle 5 -> after 100 cycles, INTERP state; DONE; read 0x9 = 10.
REQ-031 Detected edge 7 cycles after the GATE->INTERP transition -> read 0xA = 7, done_o=1.
REQ-032 sig_i constant 0, bench INTERP_MAX=20 -> COUNT=0, INTERP=20, done_o=1.
REQ-033 Write 0x81 to 0x8 mid-GATE -> IDLE next cycle, reads of 0x9/0xA = 0, busy_o=0.
REQ-034 Read 0x4 -> err_o one-cycle pulse, ack_o=0; write 0x80 to 0x8 with sel_i=4'b0010 -> ack_o pulse, state unchanged.
REQ-035 ext_rst_i pulsed low mid-INTERP -> all outputs 0 asynchronously; subsequent START runs a full 100-cycle gate.
